// File: rtl/cook_timer_pkg.sv
// Shared definitions for the egg-timer cook-time datapath.
// Holds the controller state encoding, the width of the minute/second
// fields and the largest seconds value. Also provides the clamp helper
// used when the set value is tracked or loaded.
package cook_timer_pkg;

    localparam int TW      = 6;
    localparam int SEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Saturate a time field at its limit
    function automatic logic [TW-1:0] clamp_field(input logic [TW-1:0] value,
                                                  input logic [TW-1:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// Minute/second remaining-time register for the cook timer.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   load              - capture load_min/load_sec this cycle
//   dec               - count down by one second (ignored at 0:00)
//   load_min/load_sec - value to capture on load
//   rem_min/rem_sec   - registered remaining time
//   is_one            - remaining time is exactly 0:01
module mmss_down_counter
    import cook_timer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    input  logic [TW-1:0] load_min,
    input  logic [TW-1:0] load_sec,
    output logic [TW-1:0] rem_min,
    output logic [TW-1:0] rem_sec,
    output logic          is_one
);

    logic is_zero;

    assign is_zero = (rem_min == '0) && (rem_sec == '0);
    assign is_one  = (rem_min == '0) && (rem_sec == TW'(1));

    // Load has priority over decrement. The zero guard keeps the
    // register from wrapping even if dec is asserted at 0:00.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_min <= '0;
            rem_sec <= '0;
        end else if (load) begin
            rem_min <= load_min;
            rem_sec <= load_sec;
        end else if (dec && !is_zero) begin
            if (rem_sec == '0) begin
                rem_sec <= TW'(SEC_MAX);
                rem_min <= rem_min - TW'(1);
            end else begin
                rem_sec <= rem_sec - TW'(1);
            end
        end
    end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Sequencing controller for the egg-timer cook time.
// Tracks the (clamped) set value while idle, counts it down on tick_1hz
// while running, supports pause/resume and holds a timed alarm at expiry.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   tick_1hz            - one-cycle pulse per second
//   btn_start           - start / pause / resume / acknowledge pulse
//   btn_clear           - abort / clear-setting pulse
//   set_min, set_sec    - value from the setting block
//   set_en, set_clr     - enable and clear to the setting block
//   rem_min, rem_sec    - remaining time for the display
//   state               - current state encoding
//   running, alarm      - high in RUN and DONE respectively
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int MAX_MIN    = 5,
    parameter int ALARM_SECS = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_1hz,
    input  logic          btn_start,
    input  logic          btn_clear,
    input  logic [TW-1:0] set_min,
    input  logic [TW-1:0] set_sec,
    output logic          set_en,
    output logic          set_clr,
    output logic [TW-1:0] rem_min,
    output logic [TW-1:0] rem_sec,
    output logic [1:0]    state,
    output logic          running,
    output logic          alarm
);

    localparam int CW = $clog2(ALARM_SECS + 1);

    state_t        state_q;
    state_t        next_state;
    logic [CW-1:0] alarm_cnt;
    logic          cnt_clr;
    logic          cnt_inc;
    logic [TW-1:0] clamp_min;
    logic [TW-1:0] clamp_sec;
    logic          clamp_zero;
    logic          load_en;
    logic          dec_en;
    logic          is_one;

    assign clamp_min  = clamp_field(set_min, TW'(MAX_MIN));
    assign clamp_sec  = clamp_field(set_sec, TW'(SEC_MAX));
    assign clamp_zero = (clamp_min == '0) && (clamp_sec == '0);

    // IDLE reloads every cycle, which both tracks the setting and
    // performs the load on start. A tick is dropped whenever a button
    // wins the cycle.
    assign load_en = (state_q == IDLE);
    assign dec_en  = (state_q == RUN) && tick_1hz && !btn_start && !btn_clear;

    assign state = state_q;

    mmss_down_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load_en),
        .dec      (dec_en),
        .load_min (clamp_min),
        .load_sec (clamp_sec),
        .rem_min  (rem_min),
        .rem_sec  (rem_sec),
        .is_one   (is_one)
    );

    // Next-state decode; button priority is clear > start > tick
    always_comb begin
        next_state = state_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!btn_clear && btn_start && !clamp_zero)
                    next_state = RUN;
            end
            RUN: begin
                if (btn_clear)
                    next_state = IDLE;
                else if (btn_start)
                    next_state = PAUSE;
                else if (tick_1hz && is_one) begin
                    next_state = DONE;
                    cnt_clr    = 1'b1;
                end
            end
            PAUSE: begin
                if (btn_clear)
                    next_state = IDLE;
                else if (btn_start)
                    next_state = RUN;
            end
            DONE: begin
                if (btn_clear || btn_start)
                    next_state = IDLE;
                else if (tick_1hz) begin
                    cnt_inc = 1'b1;
                    if (alarm_cnt == CW'(ALARM_SECS - 1))
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, alarm counter and registered outputs. Outputs are decoded
    // from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            alarm_cnt <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            set_en    <= 1'b1;
            set_clr   <= 1'b1;
        end else begin
            state_q <= next_state;
            running <= (next_state == RUN);
            alarm   <= (next_state == DONE);
            set_en  <= (next_state == IDLE);
            set_clr <= (state_q == IDLE) && btn_clear;
            if (cnt_clr)
                alarm_cnt <= '0;
            else if (cnt_inc)
                alarm_cnt <= alarm_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl. A behavioural model keeps the
// remaining time as total seconds; each driven cycle pushes the model's
// expected outputs to a queue, which is popped and compared once the DUT
// has clocked that cycle.
module tb_cook_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       btn_start;
    logic       btn_clear;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_en;
    logic       set_clr;
    logic [5:0] rem_min;
    logic [5:0] rem_sec;
    logic [1:0] state;
    logic       running;
    logic       alarm;

    typedef struct {
        int st;
        int rmin;
        int rsec;
        int run;
        int alm;
        int sen;
        int sclr;
    } exp_t;

    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    int m_state = 0;
    int m_rem   = 0;
    int m_cnt   = 0;
    int m_sclr  = 1;

    always #5 clk = ~clk;

    cook_timer_ctrl #(
        .MAX_MIN    (5),
        .ALARM_SECS (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .set_en    (set_en),
        .set_clr   (set_clr),
        .rem_min   (rem_min),
        .rem_sec   (rem_sec),
        .state     (state),
        .running   (running),
        .alarm     (alarm)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Reference behaviour for one clock edge
    task automatic modelStep(input bit r, input bit s, input bit c, input bit t);
        int cm, cs, cval;
        cm   = (set_min > 5)  ? 5  : int'(set_min);
        cs   = (set_sec > 59) ? 59 : int'(set_sec);
        cval = cm * 60 + cs;
        if (r) begin
            m_state = 0; m_rem = 0; m_cnt = 0; m_sclr = 1;
            return;
        end
        m_sclr = (m_state == 0 && c) ? 1 : 0;
        case (m_state)
            0: begin
                m_rem = cval;
                if (!c && s && cval != 0) m_state = 1;
            end
            1: begin
                if (c) m_state = 0;
                else if (s) m_state = 2;
                else if (t) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin m_state = 3; m_cnt = 0; end
                end
            end
            2: begin
                if (c) m_state = 0;
                else if (s) m_state = 1;
            end
            default: begin
                if (c || s) m_state = 0;
                else if (t) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 10) m_state = 0;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit c, input bit t);
        exp_t e;
        @(negedge clk);
        reset = r; btn_start = s; btn_clear = c; tick_1hz = t;
        modelStep(r, s, c, t);
        e.st   = m_state;
        e.rmin = m_rem / 60;
        e.rsec = m_rem % 60;
        e.run  = (m_state == 1) ? 1 : 0;
        e.alm  = (m_state == 3) ? 1 : 0;
        e.sen  = (m_state == 0) ? 1 : 0;
        e.sclr = m_sclr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checkOutput({phase, ".state"},   int'(state),   e.st);
        checkOutput({phase, ".rem_min"}, int'(rem_min), e.rmin);
        checkOutput({phase, ".rem_sec"}, int'(rem_sec), e.rsec);
        checkOutput({phase, ".running"}, int'(running), e.run);
        checkOutput({phase, ".alarm"},   int'(alarm),   e.alm);
        checkOutput({phase, ".set_en"},  int'(set_en),  e.sen);
        checkOutput({phase, ".set_clr"}, int'(set_clr), e.sclr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    // Tick followed by a quiet cycle, n times
    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0);
        end
    endtask

    initial begin
        reset = 1; tick_1hz = 0; btn_start = 0; btn_clear = 0;
        set_min = 0; set_sec = 5;

        phase = "reset";
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        idle(2);

        phase = "expire5";
        applyStimulus(0, 1, 0, 0);
        runTicks(5);
        phase = "alarm10";
        runTicks(10);
        idle(2);

        phase = "alarm_ack";
        applyStimulus(0, 1, 0, 0);
        runTicks(5);
        runTicks(2);
        applyStimulus(0, 1, 0, 0);
        idle(2);

        phase = "pause";
        set_min = 1; set_sec = 0;
        idle(1);
        applyStimulus(0, 1, 0, 0);
        runTicks(1);
        applyStimulus(0, 1, 0, 0);
        set_min = 3;
        runTicks(3);
        applyStimulus(0, 1, 0, 0);
        runTicks(2);

        phase = "start_clear";
        applyStimulus(0, 1, 1, 0);
        set_min = 1;
        idle(2);
        applyStimulus(0, 1, 0, 0);
        runTicks(1);
        phase = "start_tick";
        applyStimulus(0, 1, 0, 1);
        runTicks(1);
        applyStimulus(0, 0, 1, 1);
        idle(2);

        phase = "zero_start";
        set_min = 0; set_sec = 0;
        idle(1);
        applyStimulus(0, 1, 0, 0);
        idle(1);

        phase = "clamp";
        set_min = 9; set_sec = 62;
        idle(2);
        applyStimulus(0, 1, 0, 0);
        runTicks(2);
        applyStimulus(0, 0, 1, 0);
        idle(1);

        phase = "reset_mid";
        set_min = 2; set_sec = 30;
        idle(1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        idle(3);

        phase = "idle_clear";
        applyStimulus(0, 0, 1, 0);
        idle(2);
        applyStimulus(0, 1, 1, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
